// File: rtl/slot_pkg.sv
// Shared types and sizes for the slot-machine reel sequencing logic.
package slot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        DONE
    } spin_state_t;

    localparam int NUM_REELS = 3;
    localparam int SYM_W     = 3;

endpackage

// File: rtl/reel_stepper.sv
// One reel: displayed index, spinning flag and stop pulse. Steps on request and
// stops when its landing conditions all hold in the same frame update.
module reel_stepper
    import slot_pkg::*;
#(
    parameter int NUM_SYMBOLS = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             update,
    input  logic             step,
    input  logic             eligible,
    input  logic             prev_stopped,
    input  logic [SYM_W-1:0] target,
    output logic [SYM_W-1:0] idx,
    output logic             spinning,
    output logic             stop_pulse
);

    localparam logic [SYM_W-1:0] LAST_IDX = SYM_W'(NUM_SYMBOLS - 1);

    logic [SYM_W-1:0] idx_reg;
    logic [SYM_W-1:0] idx_post;
    logic             spinning_reg;
    logic             pulse_reg;
    logic             stop_now;

    always_comb begin
        idx_post = idx_reg;
        if (step) begin
            idx_post = (idx_reg == LAST_IDX) ? '0 : idx_reg + SYM_W'(1);
        end
    end

    // The landing test uses the post-step index so the reel stops on its target.
    assign stop_now = update && spinning_reg && prev_stopped && eligible && (idx_post == target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg      <= '0;
            spinning_reg <= 1'b0;
            pulse_reg    <= 1'b0;
        end else begin
            pulse_reg <= stop_now;
            if (load) begin
                spinning_reg <= 1'b1;
            end else if (update && spinning_reg) begin
                idx_reg <= idx_post;
                if (stop_now) begin
                    spinning_reg <= 1'b0;
                end
            end
        end
    end

    assign idx        = idx_reg;
    assign spinning   = spinning_reg;
    assign stop_pulse = pulse_reg;

endmodule

// File: rtl/reel_spin_scheduler.sv
// Sequences one three-reel spin on vsync frame ticks: start latch, frame and
// step counters, staggered stop eligibility and the IDLE/SPIN/DONE handshake.
module reel_spin_scheduler
    import slot_pkg::*;
#(
    parameter int NUM_SYMBOLS     = 8,
    parameter int SPEED_FRAMES    = 2,
    parameter int MIN_SPIN_FRAMES = 60,
    parameter int STAGGER_FRAMES  = 20,
    parameter int FRAME_CNT_W     = 10
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             start_spin,
    input  logic [SYM_W-1:0] final1_sprite,
    input  logic [SYM_W-1:0] final2_sprite,
    input  logic [SYM_W-1:0] final3_sprite,
    output logic [SYM_W-1:0] reel1_idx,
    output logic [SYM_W-1:0] reel2_idx,
    output logic [SYM_W-1:0] reel3_idx,
    output logic [2:0]       reel_spinning,
    output logic [2:0]       reel_stop_pulse,
    output logic             busy,
    output logic             done,
    output logic             target_err
);

    localparam int                     STEP_W    = (SPEED_FRAMES > 1) ? $clog2(SPEED_FRAMES) : 1;
    localparam logic [STEP_W-1:0]      STEP_LAST = STEP_W'(SPEED_FRAMES - 1);
    localparam logic [SYM_W:0]         SYM_LIMIT = (SYM_W + 1)'(NUM_SYMBOLS);
    localparam logic [FRAME_CNT_W-1:0] FRAME_MAX = '1;

    spin_state_t state_reg, state_next;

    logic                   vsync_prev_reg;
    logic                   start_prev_reg;
    logic                   tick;
    logic                   start_edge;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_next;
    logic [STEP_W-1:0]      step_cnt_reg, step_next;
    logic                   step_wrap;
    logic                   load;
    logic                   update;
    logic                   target_err_reg;

    logic [SYM_W-1:0]     final_in   [NUM_REELS];
    logic [SYM_W-1:0]     target_reg [NUM_REELS];
    logic [SYM_W-1:0]     idx        [NUM_REELS];
    logic [NUM_REELS-1:0] spinning;
    logic [NUM_REELS-1:0] stop_pulse;
    logic [NUM_REELS-1:0] eligible;
    logic [NUM_REELS-1:0] bad_target;

    assign final_in[0] = final1_sprite;
    assign final_in[1] = final2_sprite;
    assign final_in[2] = final3_sprite;

    assign tick       = vsync_prev_reg & ~vsync;
    assign start_edge = ~start_prev_reg & start_spin;
    assign step_wrap  = (step_cnt_reg == STEP_LAST);
    assign step_next  = step_wrap ? '0 : step_cnt_reg + STEP_W'(1);
    assign frame_next = (frame_cnt_reg == FRAME_MAX) ? frame_cnt_reg
                                                     : frame_cnt_reg + FRAME_CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        update     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    load       = 1'b1;
                    state_next = SPIN;
                end
            end
            SPIN: begin
                update = tick;
                if (spinning == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A new spin needs start_spin to drop first so IDLE sees a fresh edge.
                if (!start_spin) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            vsync_prev_reg <= 1'b1;
            start_prev_reg <= 1'b0;
            frame_cnt_reg  <= '0;
            step_cnt_reg   <= '0;
            target_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vsync_prev_reg <= vsync;
            start_prev_reg <= start_spin;
            if (load) begin
                frame_cnt_reg  <= '0;
                step_cnt_reg   <= '0;
                target_err_reg <= |bad_target;
            end else if (update) begin
                frame_cnt_reg <= frame_next;
                step_cnt_reg  <= step_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REELS; gi++) begin : g_reel
            // Widened so MIN + k*STAGGER cannot wrap against the saturating counter.
            localparam logic [FRAME_CNT_W+1:0] THRESHOLD =
                (FRAME_CNT_W + 2)'(MIN_SPIN_FRAMES + gi * STAGGER_FRAMES);

            logic prev_stopped;

            assign bad_target[gi] = ({1'b0, final_in[gi]} >= SYM_LIMIT);
            assign eligible[gi]   = ({2'b00, frame_next} >= THRESHOLD);

            if (gi == 0) begin : g_first
                assign prev_stopped = 1'b1;
            end else begin : g_later
                assign prev_stopped = ~spinning[gi-1];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    target_reg[gi] <= '0;
                end else if (load) begin
                    target_reg[gi] <= bad_target[gi] ? '0 : final_in[gi];
                end
            end

            reel_stepper #(
                .NUM_SYMBOLS (NUM_SYMBOLS)
            ) u_stepper (
                .clk          (clk),
                .reset        (reset),
                .load         (load),
                .update       (update),
                .step         (update & step_wrap),
                .eligible     (eligible[gi]),
                .prev_stopped (prev_stopped),
                .target       (target_reg[gi]),
                .idx          (idx[gi]),
                .spinning     (spinning[gi]),
                .stop_pulse   (stop_pulse[gi])
            );
        end
    endgenerate

    assign reel1_idx       = idx[0];
    assign reel2_idx       = idx[1];
    assign reel3_idx       = idx[2];
    assign reel_spinning   = spinning;
    assign reel_stop_pulse = stop_pulse;
    assign busy            = (state_reg == SPIN);
    assign done            = (state_reg == DONE);
    assign target_err      = target_err_reg;

endmodule
